renode_axi_manager_core: RTL and testbench

- Synthesizable AXI4 manager that turns single-transaction commands from local logic into AXI4 INCR read or write bursts.
- Read data is returned on a local stream; completion and error status are reported with a one-cycle done pulse.
- Sits between HDL-side test logic and any AXI4 subordinate, including the Renode-backed AXI subordinate model.
- Issues one transaction at a time, full-width beats, aligned addresses only.

---
 rtl/renode_axi_manager_core.sv | 182 ++++++++++++++++++
 tb/tb_renode_axi_manager_core.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/renode_axi_manager_core.sv
// Renode AXI4 manager core: turns one local command into one AXI4 INCR burst.
// Read beats stream out locally; completion is signalled with a done pulse.
module renode_axi_manager_core #(
    parameter int  AddressWidth       = 32,
    parameter int  DataWidth          = 32,
    parameter int  TransactionIdWidth = 8,
    localparam int StrobeWidth        = DataWidth / 8
) (
    input  logic                          clk,
    input  logic                          areset_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [AddressWidth-1:0]       cmd_addr,
    input  logic [7:0]                    cmd_len,
    input  logic [TransactionIdWidth-1:0] cmd_id,
    input  logic [DataWidth-1:0]          wr_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    output logic [DataWidth-1:0]          rd_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic                          done_valid,
    output logic                          done_error,
    output logic [TransactionIdWidth-1:0] awid,
    output logic [AddressWidth-1:0]       awaddr,
    output logic [7:0]                    awlen,
    output logic [2:0]                    awsize,
    output logic [1:0]                    awburst,
    output logic                          awvalid,
    input  logic                          awready,
    output logic [DataWidth-1:0]          wdata,
    output logic [StrobeWidth-1:0]        wstrb,
    output logic                          wlast,
    output logic                          wvalid,
    input  logic                          wready,
    input  logic [TransactionIdWidth-1:0] bid,
    input  logic [1:0]                    bresp,
    input  logic                          bvalid,
    output logic                          bready,
    output logic [TransactionIdWidth-1:0] arid,
    output logic [AddressWidth-1:0]       araddr,
    output logic [7:0]                    arlen,
    output logic [2:0]                    arsize,
    output logic [1:0]                    arburst,
    output logic                          arvalid,
    input  logic                          arready,
    input  logic [TransactionIdWidth-1:0] rid,
    input  logic [DataWidth-1:0]          rdata,
    input  logic [1:0]                    rresp,
    input  logic                          rlast,
    input  logic                          rvalid,
    output logic                          rready
);
    localparam int SizeLog2 = $clog2(StrobeWidth);

    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE
    } state_e;

    state_e                        state_q, state_d;
    logic [AddressWidth-1:0]       addr_q, addr_d;
    logic [7:0]                    len_q, len_d;
    logic [TransactionIdWidth-1:0] id_q, id_d;
    logic [8:0]                    cnt_q, cnt_d;
    logic                          err_q, err_d;

    logic        misaligned, crosses, last_beat;
    logic [31:0] end_off;

    // End offset within the 4 KiB page; exactly 4096 is still legal.
    always_comb begin
        misaligned = (cmd_addr & AddressWidth'(StrobeWidth - 1)) != '0;
        end_off    = 32'(cmd_addr[11:0]) + ((32'(cmd_len) + 32'd1) << SizeLog2);
        crosses    = end_off > 32'd4096;
    end

    assign last_beat = cnt_q == {1'b0, len_q};

    assign cmd_ready  = areset_n && (state_q == IDLE);
    assign awid       = id_q;
    assign awaddr     = addr_q;
    assign awlen      = len_q;
    assign awsize     = 3'(SizeLog2);
    assign awburst    = 2'b01;
    assign awvalid    = state_q == WR_ADDR;
    assign wdata      = (state_q == WR_DATA) ? wr_data : '0;
    assign wstrb      = '1;
    assign wvalid     = (state_q == WR_DATA) && wr_valid;
    assign wr_ready   = (state_q == WR_DATA) && wready;
    assign wlast      = (state_q == WR_DATA) && last_beat;
    assign bready     = state_q == WR_RESP;
    assign arid       = id_q;
    assign araddr     = addr_q;
    assign arlen      = len_q;
    assign arsize     = 3'(SizeLog2);
    assign arburst    = 2'b01;
    assign arvalid    = state_q == RD_ADDR;
    assign rready     = (state_q == RD_DATA) && rd_ready;
    assign rd_valid   = (state_q == RD_DATA) && rvalid;
    assign rd_data    = (state_q == RD_DATA) ? rdata : '0;
    assign done_valid = state_q == DONE;
    assign done_error = (state_q == DONE) && err_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d = cmd_addr;
                    len_d  = cmd_len;
                    id_d   = cmd_id;
                    cnt_d  = '0;
                    err_d  = misaligned || crosses;
                    if (misaligned || crosses) state_d = DONE;
                    else if (cmd_write)        state_d = WR_ADDR;
                    else                       state_d = RD_ADDR;
                end
            end
            WR_ADDR: begin
                if (awready) begin
                    state_d = WR_DATA;
                    cnt_d   = '0;
                end
            end
            WR_DATA: begin
                if (wr_valid && wready) begin
                    cnt_d = cnt_q + 9'd1;
                    if (last_beat) state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bvalid) begin
                    err_d   = err_q | bresp[1] | (bid != id_q);
                    state_d = DONE;
                end
            end
            RD_ADDR: begin
                if (arready) begin
                    state_d = RD_DATA;
                    cnt_d   = '0;
                end
            end
            RD_DATA: begin
                // A wrong rlast is only flagged; the beat count ends the burst.
                if (rvalid && rd_ready) begin
                    err_d = err_q | rresp[1] | (rid != id_q) | (rlast != last_beat);
                    cnt_d = cnt_q + 9'd1;
                    if (last_beat) state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_renode_axi_manager_core.sv
// Bench for renode_axi_manager_core: command table, mid-burst reset,
// then random commands against a subordinate memory and a reference memory.
module tb_renode_axi_manager_core;
    logic        clk = 1'b0;
    logic        areset_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len, cmd_id;
    logic [31:0] wr_data, rd_data;
    logic        wr_valid, wr_ready, rd_valid, rd_ready;
    logic        done_valid, done_error;
    logic [7:0]  awid, awlen, arid, arlen, bid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    always #5 clk = ~clk;

    renode_axi_manager_core dut (
        .clk(clk), .areset_n(areset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .done_valid(done_valid), .done_error(done_error),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid),
        .bready(bready), .arid(arid), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .arvalid(arvalid),
        .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [7:0]  id;
        int          fault;
        int          awdly;
        int          mode;
        bit          exp_err;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] smem [logic [31:0]];
    logic [31:0] rmem [logic [31:0]];

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] sword(input logic [31:0] a);
        return smem.exists(a) ? smem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] rword(input logic [31:0] a);
        return rmem.exists(a) ? rmem[a] : dflt(a);
    endfunction

    function automatic bit addr_bad(input vec_t v);
        return (v.addr[1:0] != 2'b00) ||
               (32'(v.addr[11:0]) + (32'(v.len) + 32'd1) * 32'd4 > 32'd4096);
    endfunction

    function automatic bit rb(input int mode);
        if (mode != 1) return 1'b1;
        return $urandom_range(0, 3) != 0;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic do_cmd(input vec_t v, input int abort_at);
        logic [31:0] wbeat [256];
        logic [31:0] hold_addr, aw_base, ar_base;
        int  w_cnt, r_cnt, aw_wait, viol, cyc;
        bit  aw_seen, ar_seen, b_pend, done, hold, bad;
        w_cnt = 0; r_cnt = 0; viol = 0; cyc = 0;
        aw_seen = 0; ar_seen = 0; b_pend = 0; done = 0; hold = 0;
        hold_addr = '0; aw_base = '0; ar_base = '0;
        aw_wait = v.awdly;
        bad = addr_bad(v);
        for (int i = 0; i < 256; i++)
            wbeat[i] = (v.mode == 0) ? 32'(i + 1) * 32'h11 : $urandom;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr;
        cmd_len = v.len; cmd_id = v.id;
        #1 chk("cmd_ready", cmd_ready, 1);
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            awready  = (aw_wait == 0) && rb(v.mode);
            wready   = rb(v.mode);
            arready  = rb(v.mode);
            wr_valid = (w_cnt <= int'(v.len)) && rb(v.mode);
            wr_data  = (w_cnt <= int'(v.len)) ? wbeat[w_cnt] : 32'h0;
            bvalid   = b_pend && rb(v.mode);
            bid      = (v.fault == 2) ? v.id ^ 8'h01 : v.id;
            bresp    = (v.fault == 1) ? 2'b10 : 2'($urandom_range(0, 1));
            rvalid   = ar_seen && (r_cnt <= int'(v.len)) && rb(v.mode);
            rdata    = sword(ar_base + 32'(r_cnt) * 32'd4);
            rid      = (v.fault == 5) ? v.id ^ 8'h80 : v.id;
            rresp    = (v.fault == 3 && r_cnt == 0) ? 2'b10 : 2'($urandom_range(0, 1));
            rlast    = (v.fault == 4) ? (r_cnt == 0) : (r_cnt == int'(v.len));
            rd_ready = (v.mode == 2) ? cyc[0] : rb(v.mode);
            #1;
            if ((awvalid && !v.wr) || (arvalid && v.wr)) viol++;
            if (bad && (awvalid || arvalid)) viol++;
            if (hold) chk("aw_hold", {awvalid, awaddr}, {1'b1, hold_addr});
            hold = 0;
            if (awvalid && aw_wait > 0) aw_wait--;
            if (awvalid && awready) begin
                chk("aw_fields", {awaddr, awlen, awid, awsize, awburst, wstrb},
                    {v.addr, v.len, v.id, 3'd2, 2'd1, 4'hF});
                aw_seen = 1; aw_base = awaddr;
            end else if (awvalid) begin
                hold = 1; hold_addr = awaddr;
            end
            if (wvalid && wready) begin
                chk("wdata", wdata, wbeat[w_cnt]);
                chk("wlast", wlast, w_cnt == int'(v.len));
                smem[aw_base + 32'(w_cnt) * 32'd4] = wdata;
                rmem[v.addr + 32'(w_cnt) * 32'd4] = wbeat[w_cnt];
                w_cnt++;
                if (w_cnt > int'(v.len)) b_pend = 1;
            end
            if (abort_at >= 0 && w_cnt == abort_at) begin
                areset_n = 1'b0;
                #1;
                chk("rst_ctl", {cmd_ready, awvalid, wvalid, wlast, bready, arvalid,
                                rready, rd_valid, done_valid, done_error, wr_ready}, 0);
                chk("rst_fld", {awaddr, araddr, awlen, arlen, awid, arid, wdata}, 0);
                @(negedge clk);
                areset_n = 1'b1;
                #1 chk("rst_release", cmd_ready, 1);
                return;
            end
            if (bvalid && bready) b_pend = 0;
            if (arvalid && arready) begin
                chk("ar_fields", {araddr, arlen, arid, arsize, arburst},
                    {v.addr, v.len, v.id, 3'd2, 2'd1});
                ar_seen = 1; ar_base = araddr;
            end
            if (rvalid && ar_seen && !done_valid) chk("rready", rready, rd_ready);
            if (rvalid && rready) begin
                chk("rd_data", {rd_valid, rd_data},
                    {1'b1, rword(v.addr + 32'(r_cnt) * 32'd4)});
                r_cnt++;
            end
            if (done_valid) begin
                chk("done_error", done_error, v.exp_err);
                chk("w_beats", w_cnt, (v.wr && !bad) ? int'(v.len) + 1 : 0);
                chk("r_beats", r_cnt, (!v.wr && !bad) ? int'(v.len) + 1 : 0);
                chk("chan_viol", viol, 0);
                if (bad) chk("err_latency", cyc, 0);
                done = 1;
            end
            cyc++;
        end
        if (!done) begin
            chk("timeout", 0, 1);
        end else begin
            @(negedge clk);
            #1 chk("done_pulse", {done_valid, cmd_ready}, 2'b01);
        end
    endtask

    initial begin
        vec_t tbl [13];
        vec_t v;
        areset_n = 1'b0;
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0; cmd_id = '0;
        wr_data = '0; wr_valid = 0; rd_ready = 0;
        awready = 0; wready = 0; bid = '0; bresp = '0; bvalid = 0;
        arready = 0; rid = '0; rdata = '0; rresp = '0; rlast = 0; rvalid = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 chk("reset_outs", {cmd_ready, awvalid, wvalid, wlast, bready, arvalid,
                              rready, done_valid, done_error, awaddr, awlen, awid}, 0);
        areset_n = 1'b1;
        #1 chk("ready_after_reset", cmd_ready, 1);

        smem[32'h2000] = 32'hDEAD_BEEF; rmem[32'h2000] = 32'hDEAD_BEEF;
        smem[32'h2004] = 32'hCAFE_F00D; rmem[32'h2004] = 32'hCAFE_F00D;

        tbl[0]  = vec_t'{1'b1, 32'h0100, 8'd3,   8'h05, 0, 0, 0, 1'b0};
        tbl[1]  = vec_t'{1'b0, 32'h2000, 8'd1,   8'h03, 0, 0, 2, 1'b0};
        tbl[2]  = vec_t'{1'b1, 32'h0102, 8'd0,   8'h01, 0, 0, 0, 1'b1};
        tbl[3]  = vec_t'{1'b0, 32'h0FF8, 8'd3,   8'h02, 0, 0, 0, 1'b1};
        tbl[4]  = vec_t'{1'b0, 32'h3000, 8'd1,   8'h07, 3, 0, 1, 1'b1};
        tbl[5]  = vec_t'{1'b0, 32'h3000, 8'd1,   8'h08, 4, 0, 1, 1'b1};
        tbl[6]  = vec_t'{1'b1, 32'h0400, 8'd2,   8'h0A, 2, 5, 1, 1'b1};
        tbl[7]  = vec_t'{1'b1, 32'h0FF0, 8'd3,   8'h0B, 0, 0, 1, 1'b0};
        tbl[8]  = vec_t'{1'b0, 32'h0FF0, 8'd3,   8'h0C, 0, 0, 1, 1'b0};
        tbl[9]  = vec_t'{1'b1, 32'h0800, 8'd255, 8'h0D, 0, 2, 1, 1'b0};
        tbl[10] = vec_t'{1'b0, 32'h0800, 8'd255, 8'h0E, 0, 0, 1, 1'b0};
        tbl[11] = vec_t'{1'b1, 32'h0200, 8'd0,   8'h0F, 1, 0, 0, 1'b1};
        tbl[12] = vec_t'{1'b0, 32'h0204, 8'd0,   8'h10, 5, 0, 0, 1'b1};
        for (int i = 0; i < 13; i++) do_cmd(tbl[i], -1);

        do_cmd(vec_t'{1'b1, 32'h0600, 8'd3, 8'h09, 0, 0, 0, 1'b0}, 2);
        do_cmd(vec_t'{1'b0, 32'h2000, 8'd1, 8'h04, 0, 0, 0, 1'b0}, -1);

        for (int k = 0; k < 40; k++) begin
            v.wr    = 1'($urandom_range(0, 1));
            v.addr  = 32'($urandom_range(0, 32'h1FFF)) & 32'hFFFF_FFFC;
            if ($urandom_range(0, 5) == 0)
                v.addr = 32'h1000 - 32'd4 * 32'($urandom_range(1, 8));
            if ($urandom_range(0, 7) == 0)
                v.addr = v.addr + 32'($urandom_range(1, 3));
            v.len   = 8'($urandom_range(0, 15));
            v.id    = 8'($urandom);
            v.awdly = $urandom_range(0, 3);
            v.mode  = 1;
            v.fault = 0;
            if ($urandom_range(0, 4) == 0)
                v.fault = v.wr ? $urandom_range(1, 2) : $urandom_range(3, 5);
            if (v.fault == 4 && v.len == 0) v.len = 8'd1;
            v.exp_err = addr_bad(v) || (v.fault != 0);
            do_cmd(v, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
